// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers it after
// LATENCY cycles, stalling the core while the request is in flight.
module dmem_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        Stall,
  output logic        RespValid,
  output logic [15:0] RespRData,
  output logic        AddrErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         SINGLE = (LATENCY == 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            aerr_q, aerr_d;

  logic [15:0]     mem_q [0:(1<<AW)-1];

  logic            accept;
  logic            complete;
  logic            cmp_wr;
  logic [AW-1:0]   cmp_addr;
  logic [15:0]     cmp_wdata;
  logic            cmp_err;

  assign accept = ReqValid && (state_q != S_WAIT);

  // With LATENCY==1 the request completes on its own accept edge, so the live
  // inputs are used; otherwise the completing request is the captured one.
  always_comb begin
    cmp_wr    = wr_q;
    cmp_addr  = addr_q;
    cmp_wdata = wdata_q;
    cmp_err   = err_q;
    if (accept) begin
      cmp_wr    = ReqWrite;
      cmp_addr  = ReqAddr[AW-1:0];
      cmp_wdata = ReqWData;
      cmp_err   = |ReqAddr[15:AW];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (ReqValid) begin
          wr_d     = ReqWrite;
          addr_d   = ReqAddr[AW-1:0];
          wdata_d  = ReqWData;
          err_d    = |ReqAddr[15:AW];
          cnt_d    = LAT_M1;
          state_d  = SINGLE ? S_RESP : S_WAIT;
          complete = SINGLE;
        end else if (state_q == S_RESP) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d  = S_RESP;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_d = (complete && !cmp_wr) ? mem_q[cmp_addr] : 16'h0000;
  assign aerr_d  = complete && cmp_err;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
    end
  end

  // Storage is never reset; the Rst gate keeps a request seen during reset
  // from committing.
  always_ff @(posedge Clk) begin
    if (Rst && complete && cmp_wr) begin
      mem_q[cmp_addr] <= cmp_wdata;
    end
  end

  assign Stall     = (state_q == S_WAIT);
  assign RespValid = (state_q == S_RESP);
  assign RespRData = rdata_q;
  assign AddrErr   = aerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance checked every
// cycle against a transaction-level model, plus literal response checks.
module tb_dmem_responder;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  rv, rw;
  logic [15:0] ra  [2];
  logic [15:0] rwd [2];

  logic        st0, st1, rsp0, rsp1, ae0, ae1;
  logic [15:0] rdo0, rdo1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  dmem_responder #(.AW(8), .LATENCY(2)) u_l2 (
    .Clk(Clk), .Rst(Rst), .ReqValid(rv[0]), .ReqWrite(rw[0]), .ReqAddr(ra[0]),
    .ReqWData(rwd[0]), .Stall(st0), .RespValid(rsp0), .RespRData(rdo0), .AddrErr(ae0)
  );

  dmem_responder #(.AW(8), .LATENCY(1)) u_l1 (
    .Clk(Clk), .Rst(Rst), .ReqValid(rv[1]), .ReqWrite(rw[1]), .ReqAddr(ra[1]),
    .ReqWData(rwd[1]), .Stall(st1), .RespValid(rsp1), .RespRData(rdo1), .AddrErr(ae1)
  );

  // Transaction model: a request accepted at edge n completes (commits/reads)
  // at edge n+L-1, responds in the cycle after, and the next accept is n+L.
  int          lat [2] = '{2, 1};
  longint      k = 0;
  longint      next_ok   [2] = '{0, 0};
  longint      resp_edge [2] = '{-1, -1};
  longint      resp_cyc  [2] = '{-1, -1};
  bit          pend [2] = '{0, 0};
  bit          p_wr [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_wd [2];
  logic [15:0] mm [2][256];
  logic [15:0] exp_rd [2];
  bit          exp_ae [2];

  longint      lc0[$], lc1[$];
  logic [15:0] ld0[$], ld1[$];
  bit          le0[$], le1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  initial forever begin
    @(negedge Rst);
    for (int i = 0; i < 2; i++) begin
      pend[i]      = 1'b0;
      resp_cyc[i]  = -1;
      resp_edge[i] = -1;
      next_ok[i]   = 0;
    end
  end

  initial forever begin
    @(posedge Clk);
    k++;
    if (Rst) begin
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && k >= next_ok[i]) begin
          pend[i]      = 1'b1;
          p_wr[i]      = rw[i];
          p_addr[i]    = ra[i];
          p_wd[i]      = rwd[i];
          resp_edge[i] = k + lat[i] - 1;
          next_ok[i]   = k + lat[i];
        end
        if (pend[i] && k == resp_edge[i]) begin
          if (p_wr[i]) begin
            mm[i][p_addr[i][7:0]] = p_wd[i];
            exp_rd[i] = 16'h0000;
          end else begin
            exp_rd[i] = mm[i][p_addr[i][7:0]];
          end
          exp_ae[i]   = |p_addr[i][15:8];
          resp_cyc[i] = k;
          pend[i]     = 1'b0;
        end
      end
    end
  end

  task automatic chk_out(input int i, input logic s, input logic v,
                         input logic [15:0] d, input logic e);
    bit ev;
    ev = (resp_cyc[i] == k);
    chk($sformatf("stall%0d", i), 32'(s), 32'(pend[i]));
    chk($sformatf("respvalid%0d", i), 32'(v), 32'(ev));
    if (ev) begin
      chk($sformatf("rdata%0d", i), 32'(d), 32'(exp_rd[i]));
      chk($sformatf("addrerr%0d", i), 32'(e), 32'(exp_ae[i]));
    end
    if (!Rst) begin
      chk($sformatf("rst_rdata%0d", i), 32'(d), 32'h0);
      chk($sformatf("rst_addrerr%0d", i), 32'(e), 32'h0);
    end
    if (v === 1'b1) begin
      if (i == 0) begin lc0.push_back(k); ld0.push_back(d); le0.push_back(e); end
      else        begin lc1.push_back(k); ld1.push_back(d); le1.push_back(e); end
    end
  endtask

  initial forever begin
    @(negedge Clk);
    chk_out(0, st0, rsp0, rdo0, ae0);
    chk_out(1, st1, rsp1, rdo1, ae1);
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge with
  // the request still driven so back-to-back calls keep ReqValid high.
  task automatic req(input int i, input bit w, input logic [15:0] a, input logic [15:0] d);
    bit s;
    bit done;
    done   = 1'b0;
    rv[i]  = 1'b1;
    rw[i]  = w;
    ra[i]  = a;
    rwd[i] = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      s = (i == 0) ? st0 : st1;
      @(posedge Clk);
      #1;
      if (!s) done = 1'b1;
    end
    chk($sformatf("accepted%0d", i), 32'(done), 32'h1);
  endtask

  task automatic idle(input int i);
    rv[i] = 1'b0;
    rw[i] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    Rst = 1'b1;
    rv = 2'b00; rw = 2'b00;
    ra[0] = 16'h0; ra[1] = 16'h0; rwd[0] = 16'h0; rwd[1] = 16'h0;
    #2 Rst = 1'b0;
    cycles(2);
    Rst = 1'b1;
    cycles(1);

    // preload known contents
    req(0, 1'b1, 16'h0020, 16'h1111);
    req(0, 1'b1, 16'h0009, 16'h5555);
    for (int j = 0; j < 4; j++) req(0, 1'b1, 16'(16'h0030 + j), 16'(16'hC000 + j));
    idle(0);
    req(1, 1'b1, 16'h0020, 16'h1111);
    idle(1);
    cycles(4);

    // reset held with a pending store request
    rv = 2'b11; rw = 2'b11;
    ra[0] = 16'h0020; ra[1] = 16'h0020; rwd[0] = 16'hDEAD; rwd[1] = 16'hDEAD;
    Rst = 1'b0;
    cycles(3);
    rv = 2'b00; rw = 2'b00;
    Rst = 1'b1;
    cycles(1);
    req(0, 1'b0, 16'h0020, 16'h0); idle(0);
    req(1, 1'b0, 16'h0020, 16'h0); idle(1);
    cycles(4);
    chk("rst_nostore0", 32'(ld0[ld0.size()-1]), 32'h1111);
    chk("rst_nostore1", 32'(ld1[ld1.size()-1]), 32'h1111);

    // store then load, LATENCY=2
    n0 = lc0.size();
    req(0, 1'b1, 16'h0012, 16'hBEEF);
    req(0, 1'b0, 16'h0012, 16'h0);
    idle(0);
    cycles(4);
    chk("st_ld_count", 32'(lc0.size()), 32'(n0 + 2));
    if (lc0.size() == n0 + 2) begin
      chk("st_ld_data", 32'(ld0[n0+1]), 32'hBEEF);
      chk("st_ld_err", 32'(le0[n0+1]), 32'h0);
      chk("st_ld_gap", 32'(lc0[n0+1] - lc0[n0]), 32'd2);
    end

    // four back-to-back loads
    n0 = lc0.size();
    for (int j = 0; j < 4; j++) req(0, 1'b0, 16'(16'h0030 + j), 16'h0);
    idle(0);
    cycles(4);
    chk("b2b_count", 32'(lc0.size()), 32'(n0 + 4));
    if (lc0.size() == n0 + 4) begin
      for (int j = 0; j < 4; j++) chk($sformatf("b2b_data%0d", j), 32'(ld0[n0+j]), 32'(16'hC000 + j));
      for (int j = 1; j < 4; j++) chk($sformatf("b2b_gap%0d", j), 32'(lc0[n0+j] - lc0[n0+j-1]), 32'd2);
    end

    // LATENCY=1: store then load the next cycle
    n1 = lc1.size();
    req(1, 1'b1, 16'h0005, 16'h1234);
    req(1, 1'b0, 16'h0005, 16'h0);
    idle(1);
    cycles(3);
    chk("l1_count", 32'(lc1.size()), 32'(n1 + 2));
    if (lc1.size() == n1 + 2) begin
      chk("l1_data", 32'(ld1[n1+1]), 32'h1234);
      chk("l1_gap", 32'(lc1[n1+1] - lc1[n1]), 32'd1);
    end

    // address wrap
    n0 = lc0.size();
    req(0, 1'b1, 16'h0103, 16'hA5A5);
    req(0, 1'b0, 16'h0003, 16'h0);
    idle(0);
    cycles(4);
    chk("wrap_count", 32'(lc0.size()), 32'(n0 + 2));
    if (lc0.size() == n0 + 2) begin
      chk("wrap_err_st", 32'(le0[n0]), 32'h1);
      chk("wrap_data", 32'(ld0[n0+1]), 32'hA5A5);
      chk("wrap_err_ld", 32'(le0[n0+1]), 32'h0);
    end

    // reset during WAIT aborts the store
    n0 = lc0.size();
    req(0, 1'b1, 16'h0009, 16'h7777);
    Rst = 1'b0;
    idle(0);
    cycles(2);
    Rst = 1'b1;
    cycles(3);
    chk("abort_noresp", 32'(lc0.size()), 32'(n0));
    req(0, 1'b0, 16'h0009, 16'h0);
    idle(0);
    cycles(4);
    chk("abort_count", 32'(lc0.size()), 32'(n0 + 1));
    if (lc0.size() == n0 + 1) chk("abort_data", 32'(ld0[n0]), 32'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
